// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch control slice.
package stopwatch_pkg;

  localparam int BCD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_SPLIT    = 2'd2,
    ST_PAUSED   = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_ctl_if.sv
// Board/Counter/display signals of the stopwatch controller, plus the FSM state for observation.
interface stopwatch_ctl_if;
  import stopwatch_pkg::*;

  // Buttons are raw levels; there is no valid/ready handshake on this interface.
  logic               btn_trig;
  logic               btn_split;
  logic [BCD_W-1:0]   time_reading;
  logic               count_enabled;
  logic               init_counter;
  logic               show_split;
  logic [BCD_W-1:0]   display_reading;
  state_e             dbg_state;

  modport master (
    output btn_trig, btn_split, time_reading,
    input  count_enabled, init_counter, show_split, display_reading, dbg_state
  );

  modport slave (
    input  btn_trig, btn_split, time_reading,
    output count_enabled, init_counter, show_split, display_reading, dbg_state
  );

endinterface

// File: rtl/stopwatch_ctl_btn_conditioner.sv
// Synchronizes a raw button, debounces it, and emits one registered pulse per stable press.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic init_regs_n,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count only while the synchronized level disagrees; any agreement restarts from zero.
  always_comb begin
    stable_d = stable_q;
    pulse_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctl.sv
// Stopwatch control FSM: start/stop/split/clear from two conditioned buttons, lap snapshot and display mux.
module stopwatch_ctl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            init_regs_n,
  stopwatch_ctl_if.slave  sw
);

  logic             trig_pulse, split_pulse;
  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             init_q, init_d;
  logic             show_q, show_d;
  logic [BCD_W-1:0] split_q, split_d;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig (
    .clk(clk), .init_regs_n(init_regs_n), .btn_raw(sw.btn_trig), .press_pulse(trig_pulse)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_split (
    .clk(clk), .init_regs_n(init_regs_n), .btn_raw(sw.btn_split), .press_pulse(split_pulse)
  );

  // Trig is tested first in every state so a coincident split is dropped.
  always_comb begin
    state_d = state_q;
    split_d = split_q;
    case (state_q)
      ST_IDLE:     if (trig_pulse) state_d = ST_COUNTING;
      ST_COUNTING: begin
        if (trig_pulse) state_d = ST_PAUSED;
        else if (split_pulse) begin
          state_d = ST_SPLIT;
          split_d = sw.time_reading;
        end
      end
      ST_SPLIT: begin
        if (trig_pulse)       state_d = ST_PAUSED;
        else if (split_pulse) state_d = ST_COUNTING;
      end
      ST_PAUSED: begin
        if (trig_pulse)       state_d = ST_COUNTING;
        else if (split_pulse) state_d = ST_IDLE;
      end
      default:                state_d = ST_IDLE;
    endcase
    // Outputs are decoded from the next state so they register on the same edge.
    en_d   = (state_d == ST_COUNTING) || (state_d == ST_SPLIT);
    init_d = (state_d == ST_IDLE);
    show_d = (state_d == ST_SPLIT);
  end

  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      init_q  <= 1'b1;
      show_q  <= 1'b0;
      split_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      init_q  <= init_d;
      show_q  <= show_d;
      split_q <= split_d;
    end
  end

  assign sw.count_enabled   = en_q;
  assign sw.init_counter    = init_q;
  assign sw.show_split      = show_q;
  assign sw.display_reading = show_q ? split_q : sw.time_reading;
  assign sw.dbg_state       = state_q;

endmodule
